// File: rtl/bc_trail_stack.sv
// bc_trail_stack: controller-side breadcrumb trail.
// Records crumbs arriving from the breadcrumb buffer into a LIFO held in block
// RAM, then on request replays the whole trail newest-first back into the buffer.
// Consecutive duplicate crumbs can optionally be dropped on the way in.
module bc_trail_stack #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256,
  parameter bit DEDUP  = 1'b1,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bc_in_valid,
  output logic              bc_in_rdy,
  input  logic [DATA_W-1:0] bc_in_data,
  output logic              bc_out_valid,
  input  logic              bc_out_rdy,
  output logic [DATA_W-1:0] bc_out_data,
  input  logic              retrace_start,
  input  logic              clear,
  output logic [CW-1:0]     count,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  typedef enum logic [1:0] {
    S_RECORD  = 2'd0,
    S_RETRACE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  // Trail storage; contents survive reset, only count defines what is valid.
  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q;
  logic [DATA_W-1:0] top_q;
  logic              overflow_q, overflow_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  logic              full;
  logic              in_xfer;
  logic              out_xfer;
  logic              is_dup;
  logic              push;
  logic              rd_en;
  logic [AW-1:0]     rd_addr;

  assign full = (count_q == CW'(DEPTH));

  // Ready is combinational so a start/clear request blocks the same-cycle crumb.
  assign bc_in_rdy = (state_q == S_RECORD) && !rst && !full && !retrace_start && !clear;

  assign in_xfer = bc_in_valid && bc_in_rdy;
  // A crumb offered in the same cycle as clear is treated as not taken.
  assign out_xfer = out_valid_q && bc_out_rdy && !clear;

  // top_q mirrors mem[count-1] whenever count>0 in RECORD, which avoids an
  // asynchronous RAM read for the duplicate check. count always returns to 0
  // before RECORD is re-entered from a replay, so only pushes need to track it.
  assign is_dup = DEDUP && (count_q != '0) && (bc_in_data == top_q);
  assign push   = in_xfer && !is_dup;

  // Next-state and RAM read-address selection for the record/replay sequencer.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    overflow_d  = overflow_q;
    done_d      = 1'b0;
    rd_en       = 1'b0;
    rd_addr     = '0;

    case (state_q)
      S_RECORD: begin
        if (push) begin
          count_d = count_q + CW'(1);
        end
        // Crumb is held off by backpressure; the flag just records that it happened.
        if (bc_in_valid && full) begin
          overflow_d = 1'b1;
        end
        if (retrace_start) begin
          if (count_q != '0) begin
            state_d     = S_RETRACE;
            out_valid_d = 1'b1;
            rd_en       = 1'b1;
            rd_addr     = AW'(count_q - CW'(1));
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end

      S_RETRACE: begin
        if (out_xfer) begin
          if (count_q > CW'(1)) begin
            // Prefetch the next-older crumb so replay runs at one per clock.
            count_d = count_q - CW'(1);
            rd_en   = 1'b1;
            rd_addr = AW'(count_q - CW'(2));
          end else begin
            count_d     = '0;
            out_valid_d = 1'b0;
            state_d     = S_DONE;
            done_d      = 1'b1;
          end
        end
      end

      S_DONE: begin
        state_d    = S_RECORD;
        overflow_d = 1'b0;
      end

      default: begin
        state_d = S_RECORD;
      end
    endcase

    // Clear aborts everything, including any transfer decided above.
    if (clear) begin
      state_d     = S_RECORD;
      count_d     = '0;
      overflow_d  = 1'b0;
      out_valid_d = 1'b0;
      done_d      = 1'b0;
      rd_en       = 1'b0;
    end
  end

  assign busy_d = (state_d != S_RECORD);

  // State and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_RECORD;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  // RAM write port plus the top-of-stack shadow used for duplicate detection.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[AW'(count_q)] <= bc_in_data;
      top_q             <= bc_in_data;
    end
  end

  // Registered RAM read feeding the replay data output directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q <= '0;
    end else if (rd_en) begin
      out_data_q <= mem[rd_addr];
    end
  end

  assign bc_out_valid = out_valid_q;
  assign bc_out_data  = out_data_q;
  assign count        = count_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_bc_trail_stack.sv
// Bench for bc_trail_stack: a 256-deep deduplicating instance for the main
// scenarios and a 4-deep non-deduplicating instance for the full/overflow case.
module tb_bc_trail_stack;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Large instance (DEPTH=256, DEDUP=1)
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_rdy;
  logic [15:0] in_data = '0;
  logic        out_valid;
  logic        out_rdy = 1'b0;
  logic [15:0] out_data;
  logic        retrace = 1'b0;
  logic        clr = 1'b0;
  logic [8:0]  count;
  logic        busy, done, ovf;

  // Small instance (DEPTH=4, DEDUP=0)
  logic        s_valid = 1'b0;
  logic        s_in_rdy;
  logic [15:0] s_data = '0;
  logic        s_out_valid;
  logic        s_rdy = 1'b0;
  logic [15:0] s_out_data;
  logic        s_retrace = 1'b0;
  logic        s_clr = 1'b0;
  logic [2:0]  s_count;
  logic        s_busy, s_done, s_ovf;

  bc_trail_stack #(.DATA_W(16), .DEPTH(256), .DEDUP(1'b1)) dut (
    .clk(clk), .rst(rst),
    .bc_in_valid(in_valid), .bc_in_rdy(in_rdy), .bc_in_data(in_data),
    .bc_out_valid(out_valid), .bc_out_rdy(out_rdy), .bc_out_data(out_data),
    .retrace_start(retrace), .clear(clr),
    .count(count), .busy(busy), .done(done), .overflow(ovf)
  );

  bc_trail_stack #(.DATA_W(16), .DEPTH(4), .DEDUP(1'b0)) dut_small (
    .clk(clk), .rst(rst),
    .bc_in_valid(s_valid), .bc_in_rdy(s_in_rdy), .bc_in_data(s_data),
    .bc_out_valid(s_out_valid), .bc_out_rdy(s_rdy), .bc_out_data(s_out_data),
    .retrace_start(s_retrace), .clear(s_clr),
    .count(s_count), .busy(s_busy), .done(s_done), .overflow(s_ovf)
  );

  // Reference trail contents and the replay scoreboard.
  logic [15:0] model_s[$];
  logic [15:0] exp_q[$];

  // Offer one crumb to the large instance and wait (bounded) for the handshake.
  task automatic push_crumb(input logic [15:0] d);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    #1;
    while (in_rdy !== 1'b1 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    total++;
    if (in_rdy !== 1'b1) begin
      bad++;
      $display("FAIL push_handshake data=%h: rdy=%b want 1", d, in_rdy);
    end else if (!(model_s.size() > 0 && model_s[$] == d)) begin
      model_s.push_back(d);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Start a replay on the large instance and drain it under a ready pattern.
  task automatic run_retrace(input string tag, input logic [15:0] rdy_pat, input int exp_done_cyc);
    int done_cyc = -1;
    logic [15:0] want;
    exp_q.delete();
    for (int i = model_s.size() - 1; i >= 0; i--) exp_q.push_back(model_s[i]);
    @(negedge clk);
    retrace = 1'b1;
    out_rdy = 1'b0;
    #1;
    total++;
    if (in_rdy !== 1'b0) begin
      bad++;
      $display("FAIL %s rdy_during_start: got %b want 0", tag, in_rdy);
    end
    for (int cyc = 1; cyc <= 16; cyc++) begin
      @(negedge clk);
      retrace = 1'b0;
      out_rdy = rdy_pat[cyc-1];
      #1;
      total++;
      if (busy !== 1'b1) begin
        bad++;
        $display("FAIL %s busy cyc=%0d: got %b want 1", tag, cyc, busy);
      end
      if (done === 1'b1) begin
        done_cyc = cyc;
        total++;
        if (out_valid !== 1'b0) begin
          bad++;
          $display("FAIL %s valid_at_done: got %b want 0", tag, out_valid);
        end
        break;
      end
      total++;
      if (out_valid !== 1'b1 || exp_q.size() == 0) begin
        bad++;
        $display("FAIL %s out_valid cyc=%0d: got %b want 1 (pending %0d)", tag, cyc, out_valid, exp_q.size());
      end else begin
        if (out_rdy) want = exp_q.pop_front();
        else want = exp_q[0];
        total++;
        if (out_data !== want) begin
          bad++;
          $display("FAIL %s out_data cyc=%0d rdy=%b: got %h want %h", tag, cyc, out_rdy, out_data, want);
        end else begin
          $display("%s cyc=%0d rdy=%b crumb=%h", tag, cyc, out_rdy, out_data);
        end
      end
    end
    total++;
    if (done_cyc != exp_done_cyc) begin
      bad++;
      $display("FAIL %s done_cycle: got %0d want %0d", tag, done_cyc, exp_done_cyc);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s scoreboard_left: got %0d want 0", tag, exp_q.size());
    end
    @(negedge clk);
    out_rdy = 1'b0;
    #1;
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || count !== 9'd0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s after_done: done=%b busy=%b count=%0d valid=%b want 0 0 0 0", tag, done, busy, count, out_valid);
    end
    model_s.delete();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = 16'h1234;
    s_valid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (in_rdy !== 1'b0 || s_in_rdy !== 1'b0) begin
      bad++;
      $display("FAIL reset_rdy: got %b/%b want 0/0", in_rdy, s_in_rdy);
    end
    total++;
    if (count !== 9'd0 || out_valid !== 1'b0 || out_data !== 16'h0000) begin
      bad++;
      $display("FAIL reset_state: count=%0d valid=%b data=%h want 0 0 0000", count, out_valid, out_data);
    end
    total++;
    if (done !== 1'b0 || ovf !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags: done=%b ovf=%b busy=%b want 0 0 0", done, ovf, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    s_valid = 1'b0;
    #1;
    total++;
    if (in_rdy !== 1'b1) begin
      bad++;
      $display("FAIL reset_release_rdy: got %b want 1", in_rdy);
    end
    $display("reset checked");
  endtask

  task automatic test_basic;
    push_crumb(16'h0001);
    push_crumb(16'h0002);
    push_crumb(16'h0003);
    #1;
    total++;
    if (count !== 9'd3) begin
      bad++;
      $display("FAIL t1_count: got %0d want 3", count);
    end
    run_retrace("t1", 16'hFFFF, 4);
  endtask

  task automatic test_stall;
    push_crumb(16'h0001);
    push_crumb(16'h0002);
    push_crumb(16'h0003);
    run_retrace("t2", 16'hFFF9, 6);
  endtask

  task automatic test_overflow;
    logic [15:0] acc[$];
    logic        want_rdy;
    @(negedge clk);
    s_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      s_data = 16'h000A + 16'(i);
      #1;
      want_rdy = (i < 4);
      total++;
      if (s_in_rdy !== want_rdy) begin
        bad++;
        $display("FAIL t3_rdy offer=%h: got %b want %b", s_data, s_in_rdy, want_rdy);
      end
      if (want_rdy) acc.push_back(s_data);
      $display("t3 offer=%h rdy=%b", s_data, s_in_rdy);
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_retrace = 1'b1;
    s_rdy = 1'b1;
    #1;
    total++;
    if (s_ovf !== 1'b1 || s_count !== 3'd4) begin
      bad++;
      $display("FAIL t3_full: ovf=%b count=%0d want 1 4", s_ovf, s_count);
    end
    exp_q.delete();
    for (int i = acc.size() - 1; i >= 0; i--) exp_q.push_back(acc[i]);
    for (int k = 0; k < 4; k++) begin
      logic [15:0] want;
      @(negedge clk);
      s_retrace = 1'b0;
      #1;
      want = exp_q.pop_front();
      total++;
      if (s_out_valid !== 1'b1 || s_out_data !== want) begin
        bad++;
        $display("FAIL t3_replay k=%0d: valid=%b data=%h want 1 %h", k, s_out_valid, s_out_data, want);
      end else begin
        $display("t3 replay crumb=%h", s_out_data);
      end
    end
    @(negedge clk);
    #1;
    total++;
    if (s_done !== 1'b1) begin
      bad++;
      $display("FAIL t3_done: got %b want 1", s_done);
    end
    @(negedge clk);
    s_rdy = 1'b0;
    #1;
    total++;
    if (s_done !== 1'b0 || s_ovf !== 1'b0 || s_count !== 3'd0 || s_busy !== 1'b0) begin
      bad++;
      $display("FAIL t3_after: done=%b ovf=%b count=%0d busy=%b want 0 0 0 0", s_done, s_ovf, s_count, s_busy);
    end
  endtask

  task automatic test_dedup;
    push_crumb(16'h0055);
    push_crumb(16'h0055);
    push_crumb(16'h0066);
    push_crumb(16'h0055);
    #1;
    total++;
    if (count !== 9'd3) begin
      bad++;
      $display("FAIL t4_count: got %0d want 3", count);
    end
    run_retrace("t4", 16'hFFFF, 4);
  endtask

  task automatic test_empty;
    run_retrace("t5", 16'hFFFF, 1);
  endtask

  task automatic test_abort(input bit use_rst);
    string tag;
    tag = use_rst ? "t6rst" : "t6clr";
    for (int i = 0; i < 5; i++) push_crumb(16'h0010 + 16'(i));
    #1;
    total++;
    if (count !== 9'd5) begin
      bad++;
      $display("FAIL %s count: got %0d want 5", tag, count);
    end
    @(negedge clk);
    retrace = 1'b1;
    out_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      logic [15:0] want;
      @(negedge clk);
      retrace = 1'b0;
      out_rdy = 1'b1;
      if (k == 2) begin
        if (use_rst) rst = 1'b1;
        else clr = 1'b1;
      end
      #1;
      want = 16'h0014 - 16'(k);
      total++;
      if (out_valid !== 1'b1 || out_data !== want || done !== 1'b0) begin
        bad++;
        $display("FAIL %s replay k=%0d: valid=%b data=%h done=%b want 1 %h 0", tag, k, out_valid, out_data, done, want);
      end else begin
        $display("%s presented crumb=%h", tag, out_data);
      end
    end
    total++;
    if (in_rdy !== 1'b0) begin
      bad++;
      $display("FAIL %s rdy_during_abort: got %b want 0", tag, in_rdy);
    end
    @(negedge clk);
    rst = 1'b0;
    clr = 1'b0;
    out_rdy = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || count !== 9'd0 || busy !== 1'b0 || done !== 1'b0 || in_rdy !== 1'b1) begin
      bad++;
      $display("FAIL %s after_abort: valid=%b count=%0d busy=%b done=%b rdy=%b want 0 0 0 0 1",
               tag, out_valid, count, busy, done, in_rdy);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      total++;
      if (done !== 1'b0 || out_valid !== 1'b0) begin
        bad++;
        $display("FAIL %s quiet k=%0d: done=%b valid=%b want 0 0", tag, k, done, out_valid);
      end
    end
    model_s.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_overflow();
    test_dedup();
    test_empty();
    test_abort(1'b0);
    test_abort(1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
